// File: rtl/crc_pkg.sv
// Shared types, CRC-32 constants and the bit-serial byte fold used by the parallel CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } crc_state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

    // Reflected CRC: bits of the byte enter LSb first.
    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data_byte,
        input logic [31:0] poly
    );
        logic [31:0] c;
        c = crc;
        for (int b = 0; b < 8; b++) begin
            c = (c[0] ^ data_byte[b]) ? ((c >> 1) ^ poly) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_engine_par_if.sv
// Message-in / result-out bundle of crc_engine_par, including the FSM state for observation.
interface crc_engine_par_if #(
    parameter int MSG_BYTES = 40
);
    import crc_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // out_valid with crc_out/crc_match is held stable until that transfer.
    logic                   in_valid;
    logic                   in_ready;
    logic [8*MSG_BYTES-1:0] data_in;
    logic                   check_en;
    logic [31:0]            expect_crc;
    logic                   abort;
    logic                   out_valid;
    logic                   out_ready;
    logic [31:0]            crc_out;
    logic                   crc_match;
    logic                   busy;
    crc_state_t             state;

    modport master (
        output in_valid, data_in, check_en, expect_crc, abort, out_ready,
        input  in_ready, out_valid, crc_out, crc_match, busy, state
    );

    modport slave (
        input  in_valid, data_in, check_en, expect_crc, abort, out_ready,
        output in_ready, out_valid, crc_out, crc_match, busy, state
    );

endinterface

// File: rtl/crc32_unroll.sv
// Combinational fold of one group of BYTES_PER_CYC bytes into a running reflected CRC-32.
module crc32_unroll
    import crc_pkg::*;
#(
    parameter int          BYTES_PER_CYC = 4,
    parameter logic [31:0] POLY          = CRC32_POLY_REFL
) (
    input  logic [31:0]                crc_in,
    input  logic [8*BYTES_PER_CYC-1:0] data,
    output logic [31:0]                crc_next
);

    // First byte of the group sits in the most significant position.
    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < BYTES_PER_CYC; i++) begin
            c = crc32_byte(c, data[8*(BYTES_PER_CYC-1-i) +: 8], POLY);
        end
        crc_next = c;
    end

endmodule

// File: rtl/crc_engine_par.sv
// Multicycle CRC-32 engine: captures a fixed-length message, folds BYTES_PER_CYC bytes per
// clock, and returns the CRC (plus optional compare against an expected value) on a held output.
module crc_engine_par
    import crc_pkg::*;
#(
    parameter int          MSG_BYTES     = 40,
    parameter int          BYTES_PER_CYC = 4,
    parameter logic [31:0] POLY          = CRC32_POLY_REFL,
    parameter logic [31:0] INIT          = CRC32_INIT,
    parameter logic [31:0] XOROUT        = CRC32_XOROUT
) (
    input  logic             clk,
    input  logic             rst,
    crc_engine_par_if.slave  bus
);

    localparam int IDXW     = $clog2(MSG_BYTES + 1);
    localparam int NGRP     = MSG_BYTES / BYTES_PER_CYC;
    localparam int GRPW     = 8 * BYTES_PER_CYC;
    localparam int MSGW     = 8 * MSG_BYTES;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MSG_BYTES - BYTES_PER_CYC);
    localparam logic [IDXW-1:0] STEP     = IDXW'(BYTES_PER_CYC);

    if (MSG_BYTES < 1 || BYTES_PER_CYC < 1 || (MSG_BYTES % BYTES_PER_CYC) != 0) begin : g_bad_params
        $error("crc_engine_par: BYTES_PER_CYC must divide MSG_BYTES");
    end

    crc_state_t      state;
    crc_state_t      state_next;
    logic [MSGW-1:0] msg_reg;
    logic [MSGW-1:0] msg_shifted;
    logic [31:0]     crc_reg;
    logic [31:0]     crc_next;
    logic [31:0]     crc_final;
    logic [IDXW-1:0] idx;
    logic            chk_reg;
    logic [31:0]     exp_reg;
    logic            accept;
    logic            last_grp;
    logic            result_taken;

    // The group being folded is always the top GRPW bits; the register shifts left each cycle.
    if (NGRP > 1) begin : g_shift
        assign msg_shifted = {msg_reg[MSGW-GRPW-1:0], {GRPW{1'b0}}};
    end else begin : g_noshift
        assign msg_shifted = msg_reg;
    end

    crc32_unroll #(
        .BYTES_PER_CYC (BYTES_PER_CYC),
        .POLY          (POLY)
    ) u_unroll (
        .crc_in   (crc_reg),
        .data     (msg_reg[MSGW-1 -: GRPW]),
        .crc_next (crc_next)
    );

    assign crc_final = crc_next ^ XOROUT;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (bus.in_valid)  state_next = ST_COMPUTE;
                ST_COMPUTE: if (last_grp)      state_next = ST_DONE;
                ST_DONE:    if (bus.out_ready) state_next = ST_IDLE;
                default:                       state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode and datapath strobes
    always_comb begin
        bus.in_ready = (state == ST_IDLE);
        accept       = (state == ST_IDLE) && bus.in_valid;
        last_grp     = (state == ST_COMPUTE) && (idx == LAST_IDX);
        result_taken = (state == ST_DONE) && bus.out_ready;
    end

    assign bus.state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_reg       <= '0;
            crc_reg       <= INIT;
            idx           <= '0;
            chk_reg       <= 1'b0;
            exp_reg       <= '0;
            bus.out_valid <= 1'b0;
            bus.crc_out   <= '0;
            bus.crc_match <= 1'b0;
            bus.busy      <= 1'b0;
        end else if (bus.abort) begin
            crc_reg       <= INIT;
            idx           <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            if (accept) begin
                msg_reg  <= bus.data_in;
                chk_reg  <= bus.check_en;
                exp_reg  <= bus.expect_crc;
                crc_reg  <= INIT;
                idx      <= '0;
                bus.busy <= 1'b1;
            end
            if (state == ST_COMPUTE) begin
                crc_reg <= crc_next;
                idx     <= idx + STEP;
                msg_reg <= msg_shifted;
            end
            if (last_grp) begin
                bus.crc_out   <= crc_final;
                bus.crc_match <= chk_reg && (crc_final == exp_reg);
                bus.out_valid <= 1'b1;
                bus.busy      <= 1'b0;
            end
            if (result_taken) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_crc_engine_par.sv
// Directed bench for crc_engine_par: check vectors at several group widths, compare mode,
// held output, abort, asynchronous reset and back-to-back throughput.
module tb_crc_engine_par;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    crc_engine_par_if #(.MSG_BYTES(9))  b9a ();
    crc_engine_par_if #(.MSG_BYTES(9))  b9b ();
    crc_engine_par_if #(.MSG_BYTES(9))  b9c ();
    crc_engine_par_if #(.MSG_BYTES(4))  b4 ();
    crc_engine_par_if #(.MSG_BYTES(40)) bd ();

    crc_engine_par #(.MSG_BYTES(9), .BYTES_PER_CYC(1)) u9a (.clk(clk), .rst(rst), .bus(b9a.slave));
    crc_engine_par #(.MSG_BYTES(9), .BYTES_PER_CYC(3)) u9b (.clk(clk), .rst(rst), .bus(b9b.slave));
    crc_engine_par #(.MSG_BYTES(9), .BYTES_PER_CYC(9)) u9c (.clk(clk), .rst(rst), .bus(b9c.slave));
    crc_engine_par #(.MSG_BYTES(4), .BYTES_PER_CYC(4)) u4  (.clk(clk), .rst(rst), .bus(b4.slave));
    crc_engine_par #(.MSG_BYTES(40), .BYTES_PER_CYC(4)) ud (.clk(clk), .rst(rst), .bus(bd.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference, byte 0 in the top byte of the first n bytes.
    function automatic logic [31:0] model(input logic [319:0] msg, input int n);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            b = msg[8*n-1-8*i -: 8];
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
                else             c = c >> 1;
            end
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    task automatic rand_msg(output logic [319:0] m);
        for (int i = 0; i < 10; i++) m[32*i +: 32] = $urandom();
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_d(input logic [319:0] msg, input logic ck, input logic [31:0] ex, input bit push);
        logic [319:0] junk;
        int t;
        t = 0;
        while (!bd.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", bd.in_ready, 1);
        bd.data_in    = msg;
        bd.check_en   = ck;
        bd.expect_crc = ex;
        bd.in_valid   = 1'b1;
        if (push) exp_q.push_back(model(msg, 40));
        @(posedge clk);
        @(negedge clk);
        bd.in_valid = 1'b0;
        rand_msg(junk);
        bd.data_in    = junk;
        bd.check_en   = ~ck;
        bd.expect_crc = ~ex;
    endtask

    task automatic wait_out(input string tag, output int lat);
        lat = 0;
        while (!bd.out_valid && lat < 30) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, bd.out_valid, 1);
    endtask

    task automatic sb_check(input string tag, input logic exp_match);
        logic [31:0] e;
        chk({tag, "_qnonempty"}, 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_crc"}, bd.crc_out, e);
            chk({tag, "_match"}, bd.crc_match, exp_match);
        end
    endtask

    initial begin
        logic [319:0] m;
        logic [31:0]  e;
        int lat, lat_a, lat_b, lat_c, w, seen;
        int last_cyc, n_res, n_push;
        bit acc_prev;
        logic [71:0] str9;
        logic        ck4 [3];
        logic [31:0] ex4 [3];
        logic        mt4 [3];

        str9 = 72'h313233343536373839;
        ck4 = '{1'b0, 1'b1, 1'b1};
        ex4 = '{32'h0, 32'h2144DF1C, 32'h2144DF1D};
        mt4 = '{1'b0, 1'b1, 1'b0};

        b9a.in_valid = 0; b9a.data_in = '0; b9a.check_en = 0; b9a.expect_crc = '0; b9a.abort = 0; b9a.out_ready = 0;
        b9b.in_valid = 0; b9b.data_in = '0; b9b.check_en = 0; b9b.expect_crc = '0; b9b.abort = 0; b9b.out_ready = 0;
        b9c.in_valid = 0; b9c.data_in = '0; b9c.check_en = 0; b9c.expect_crc = '0; b9c.abort = 0; b9c.out_ready = 0;
        b4.in_valid  = 0; b4.data_in  = '0; b4.check_en  = 0; b4.expect_crc  = '0; b4.abort  = 0; b4.out_ready  = 0;
        bd.in_valid  = 0; bd.data_in  = '0; bd.check_en  = 0; bd.expect_crc  = '0; bd.abort  = 0; bd.out_ready  = 0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bd.in_ready, 1);
        chk("rst_out_valid", bd.out_valid, 0);
        chk("rst_crc_out", bd.crc_out, 0);
        chk("rst_crc_match", bd.crc_match, 0);
        chk("rst_busy", bd.busy, 0);
        chk("rst_state", 32'(bd.state), 32'(ST_IDLE));
        rst = 1'b1;
        @(negedge clk);

        // "123456789" at 1, 3 and 9 bytes per cycle
        b9a.data_in = str9; b9b.data_in = str9; b9c.data_in = str9;
        b9a.in_valid = 1; b9b.in_valid = 1; b9c.in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        b9a.in_valid = 0; b9b.in_valid = 0; b9c.in_valid = 0;
        b9a.data_in = '0; b9b.data_in = '0; b9c.data_in = '0;
        chk("s9_ready_low", b9a.in_ready, 0);
        chk("s9_busy", b9a.busy, 1);
        lat_a = 0; lat_b = 0; lat_c = 0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (b9a.out_valid && lat_a == 0) lat_a = c;
            if (b9b.out_valid && lat_b == 0) lat_b = c;
            if (b9c.out_valid && lat_c == 0) lat_c = c;
        end
        chk("s9_lat_bpc1", lat_a, 9);
        chk("s9_lat_bpc3", lat_b, 3);
        chk("s9_lat_bpc9", lat_c, 1);
        chk("s9_crc_bpc1", b9a.crc_out, 32'hCBF43926);
        chk("s9_crc_bpc3", b9b.crc_out, 32'hCBF43926);
        chk("s9_crc_bpc9", b9c.crc_out, 32'hCBF43926);
        chk("s9_model", model({248'h0, str9}, 9), 32'hCBF43926);
        chk("s9_match_off", b9b.crc_match, 0);
        b9a.out_ready = 1; b9b.out_ready = 1; b9c.out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        b9a.out_ready = 0; b9b.out_ready = 0; b9c.out_ready = 0;
        chk("s9_release_valid", b9b.out_valid, 0);
        chk("s9_release_ready", b9b.in_ready, 1);
        chk("s9_crc_kept", b9b.crc_out, 32'hCBF43926);

        // All-zero 4-byte message, compare off / match / mismatch
        for (int t = 0; t < 3; t++) begin
            b4.data_in = '0; b4.check_en = ck4[t]; b4.expect_crc = ex4[t]; b4.in_valid = 1;
            @(posedge clk);
            @(negedge clk);
            b4.in_valid = 0; b4.check_en = ~ck4[t]; b4.expect_crc = ~ex4[t];
            w = 0;
            while (!b4.out_valid && w < 10) begin
                @(posedge clk);
                @(negedge clk);
                w++;
            end
            chk("z4_valid", b4.out_valid, 1);
            chk("z4_crc", b4.crc_out, 32'h2144DF1C);
            chk("z4_match", b4.crc_match, mt4[t]);
            b4.out_ready = 1;
            @(posedge clk);
            @(negedge clk);
            b4.out_ready = 0;
        end

        // Random 40-byte message, result held while out_ready is low
        rand_msg(m);
        send_d(m, 1'b0, 32'h0, 1'b1);
        wait_out("rnd", lat);
        chk("rnd_latency", lat, 10);
        e = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("hold_valid", bd.out_valid, 1);
            chk("hold_crc", bd.crc_out, e);
            chk("hold_in_ready", bd.in_ready, 0);
        end
        sb_check("rnd", 1'b0);
        bd.out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        bd.out_ready = 0;
        chk("rnd_release_valid", bd.out_valid, 0);
        chk("rnd_release_ready", bd.in_ready, 1);

        // Abort in the fifth compute cycle, then a fresh message
        rand_msg(m);
        send_d(m, 1'b0, 32'h0, 1'b0);
        repeat (4) @(negedge clk);
        bd.abort = 1;
        @(posedge clk);
        @(negedge clk);
        bd.abort = 0;
        chk("abort_ready", bd.in_ready, 1);
        chk("abort_busy", bd.busy, 0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bd.out_valid) seen = 1;
        end
        chk("abort_quiet", seen, 0);
        rand_msg(m);
        send_d(m, 1'b0, 32'h0, 1'b1);
        wait_out("post_abort", lat);
        sb_check("post_abort", 1'b0);
        bd.out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        bd.out_ready = 0;

        // Asynchronous reset in the middle of COMPUTE
        rand_msg(m);
        send_d(m, 1'b0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_in_ready", bd.in_ready, 1);
        chk("arst_out_valid", bd.out_valid, 0);
        chk("arst_crc_out", bd.crc_out, 0);
        chk("arst_busy", bd.busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rand_msg(m);
        send_d(m, 1'b1, model(m, 40), 1'b1);
        wait_out("post_rst", lat);
        chk("post_rst_latency", lat, 10);
        sb_check("post_rst", 1'b1);
        bd.out_ready = 1;
        @(posedge clk);
        @(negedge clk);

        // Back-to-back messages with both handshakes held high
        rand_msg(m);
        bd.data_in = m; bd.check_en = 0; bd.in_valid = 1; bd.out_ready = 1;
        acc_prev = 0; last_cyc = -1; n_res = 0; n_push = 0;
        for (int cyc = 0; cyc < 80 && n_res < 6; cyc++) begin
            if (bd.out_valid) begin
                sb_check("b2b", 1'b0);
                if (last_cyc >= 0) chk("b2b_gap", cyc - last_cyc, 12);
                last_cyc = cyc;
                n_res++;
            end
            acc_prev = bd.in_ready;
            if (bd.in_ready) begin
                exp_q.push_back(model(bd.data_in, 40));
                n_push++;
            end
            @(negedge clk);
            if (acc_prev) begin
                rand_msg(m);
                bd.data_in = m;
            end
        end
        bd.in_valid = 0;
        for (int c = 0; c < 15 && exp_q.size() > 0; c++) begin
            if (bd.out_valid) begin
                sb_check("b2b_drain", 1'b0);
                n_res++;
            end
            @(negedge clk);
        end
        chk("b2b_results", n_res, n_push);
        chk("b2b_q_empty", exp_q.size(), 0);
        chk("b2b_min_results", 32'(n_res >= 6), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
